// File: rtl/program_counter_ras_if.sv
// Request/status bundle between the decode/branch unit and the program counter.
// The decode side is the master; the program counter is the slave.
interface program_counter_ras_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  logic                           stall;
  logic                           branch_en;
  logic [WIDTH-1:0]               branch_offset;
  logic                           jump_en;
  logic                           call_en;
  logic                           ret_en;
  logic [WIDTH-1:0]               jump_target;
  logic [WIDTH-1:0]               pc_out;
  logic [$clog2(RAS_DEPTH):0]     ras_count;
  logic                           ras_empty;
  logic                           ras_full;
  logic                           ras_overflow;
  logic                           ras_underflow;
  logic                           align_err;

  modport master (
    output stall, branch_en, branch_offset, jump_en, call_en, ret_en, jump_target,
    input  pc_out, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow, align_err
  );

  modport slave (
    input  stall, branch_en, branch_offset, jump_en, call_en, ret_en, jump_target,
    output pc_out, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow, align_err
  );
endinterface

// File: rtl/program_counter_ras.sv
// Fetch-address register with stall, branch, jump, call/return and a circular
// return-address stack that overwrites its oldest entry when full.
module program_counter_ras #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rst,
  program_counter_ras_if.slave bus
);
  localparam int unsigned      PW       = $clog2(RAS_DEPTH);
  localparam int unsigned      CW       = PW + 1;
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]    DEPTH    = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_CALL,
    ACT_JUMP,
    ACT_BRANCH,
    ACT_INC
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] seq_pc, raw_tgt;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             aerr_q, aerr_d;
  logic             push;

  always_comb begin
    if (bus.stall)          act = ACT_HOLD;
    else if (bus.ret_en)    act = ACT_RET;
    else if (bus.call_en)   act = ACT_CALL;
    else if (bus.jump_en)   act = ACT_JUMP;
    else if (bus.branch_en) act = ACT_BRANCH;
    else                    act = ACT_INC;
  end

  // Top of stack is always the slot just behind the write pointer, even after wrap.
  always_comb begin
    seq_pc  = pc_q + STEP;
    raw_tgt = (act == ACT_BRANCH) ? (pc_q + bus.branch_offset) : bus.jump_target;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    aerr_d  = 1'b0;
    push    = 1'b0;
    case (act)
      ACT_RET: begin
        if (cnt_q != '0) begin
          pc_d   = ras_q[wptr_q - 1'b1];
          wptr_d = wptr_q - 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          pc_d  = seq_pc;
          unf_d = 1'b1;
        end
      end
      ACT_CALL: begin
        push   = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (cnt_q == DEPTH) ovf_d = 1'b1;
        else                cnt_d = cnt_q + 1'b1;
        pc_d   = raw_tgt & ~LOW_MASK;
        aerr_d = |(raw_tgt & LOW_MASK);
      end
      ACT_JUMP, ACT_BRANCH: begin
        pc_d   = raw_tgt & ~LOW_MASK;
        aerr_d = |(raw_tgt & LOW_MASK);
      end
      ACT_INC: pc_d = seq_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      wptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      aerr_q <= aerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[wptr_q] <= seq_pc;
  end

  assign bus.pc_out        = pc_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_empty     = (cnt_q == '0);
  assign bus.ras_full      = (cnt_q == DEPTH);
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
  assign bus.align_err     = aerr_q;
endmodule
